// File: rtl/dpe_rr_mux_if.sv
// Stream bundle for dpe_rr_mux: N_CH ingress channels in, one channel-tagged DPE stream out.
// slave is the mux view; master is the environment (ingress sources plus downstream sink).
interface dpe_rr_mux_if #(
    parameter int N_CH   = 5,
    parameter int DATA_W = 64,
    parameter int USER_W = 4,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH*DATA_W-1:0]   s_tdata;
    logic [N_CH*DATA_W/8-1:0] s_tkeep;
    logic [N_CH*USER_W-1:0]   s_tuser;
    logic [N_CH-1:0]          s_tlast;
    logic [N_CH-1:0]          s_tvalid;
    logic [N_CH-1:0]          s_tready;

    logic [DATA_W-1:0]        m_tdata;
    logic [DATA_W/8-1:0]      m_tkeep;
    logic [USER_W-1:0]        m_tuser;
    logic [CH_W-1:0]          m_tid;
    logic                     m_tlast;
    logic                     m_tvalid;
    logic                     m_tready;

    modport slave (
        input  s_tdata, s_tkeep, s_tuser, s_tlast, s_tvalid,
        output s_tready,
        output m_tdata, m_tkeep, m_tuser, m_tid, m_tlast, m_tvalid,
        input  m_tready
    );

    modport master (
        output s_tdata, s_tkeep, s_tuser, s_tlast, s_tvalid,
        input  s_tready,
        input  m_tdata, m_tkeep, m_tuser, m_tid, m_tlast, m_tvalid,
        output m_tready
    );
endinterface

// File: rtl/dpe_rr_mux.sv
// Packet-atomic round-robin AXI-Stream mux: bursts of up to BURST whole packets per grant,
// registered output slice tagged with the source channel, pause drains at packet boundaries.
module dpe_rr_mux #(
    parameter int N_CH   = 5,
    parameter int DATA_W = 64,
    parameter int USER_W = 4,
    parameter int BURST  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    output logic        is_idle,
    dpe_rr_mux_if.slave bus
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {StArb, StXfer} state_e;

    state_e            r_state;
    logic [CH_W-1:0]   r_grant;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [7:0]        r_pkt_cnt;

    logic              r_m_tvalid;
    logic              r_m_tlast;
    logic [DATA_W-1:0] r_m_tdata;
    logic [KEEP_W-1:0] r_m_tkeep;
    logic [USER_W-1:0] r_m_tuser;
    logic [CH_W-1:0]   r_m_tid;
    logic              r_is_idle;

    logic [CH_W-1:0]   w_sel;
    logic [CH_W-1:0]   w_ptr_next;
    logic [N_CH-1:0]   w_s_tready;
    logic              w_any;
    logic              w_slice_free;
    logic              w_accept;
    logic              w_last;
    logic              w_burst_more;
    logic              w_tvalid_next;
    logic [DATA_W-1:0] w_tdata;
    logic [KEEP_W-1:0] w_tkeep;
    logic [USER_W-1:0] w_tuser;

    // Descending scan so the lowest offset from r_rr_ptr is the last (winning) assignment.
    always_comb begin
        w_sel = r_rr_ptr;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.s_tvalid[(int'(r_rr_ptr) + i) % N_CH]) begin
                w_sel = CH_W'((int'(r_rr_ptr) + i) % N_CH);
            end
        end
    end

    assign w_any         = |bus.s_tvalid;
    assign w_slice_free  = !r_m_tvalid || bus.m_tready;
    assign w_accept      = (r_state == StXfer) && bus.s_tvalid[r_grant] && w_slice_free;
    assign w_last        = bus.s_tlast[r_grant];
    assign w_burst_more  = (({1'b0, r_pkt_cnt} + 9'd1) < 9'(BURST)) && !pause
                           && bus.s_tvalid[r_grant];
    assign w_ptr_next    = (r_grant == CH_W'(N_CH - 1)) ? '0 : r_grant + CH_W'(1);
    assign w_tvalid_next = w_accept || (r_m_tvalid && !bus.m_tready);

    assign w_tdata = bus.s_tdata[int'(r_grant) * DATA_W +: DATA_W];
    assign w_tkeep = bus.s_tkeep[int'(r_grant) * KEEP_W +: KEEP_W];
    assign w_tuser = bus.s_tuser[int'(r_grant) * USER_W +: USER_W];

    always_comb begin
        w_s_tready = '0;
        if (r_state == StXfer) begin
            w_s_tready[r_grant] = w_slice_free;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StArb;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_pkt_cnt  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tid    <= '0;
            r_is_idle  <= 1'b0;
        end else begin
            unique case (r_state)
                StArb: begin
                    if (!pause && w_any) begin
                        r_grant   <= w_sel;
                        r_pkt_cnt <= '0;
                        r_state   <= StXfer;
                    end
                end
                StXfer: begin
                    // Grant only moves at a tlast, so packets are never interleaved.
                    if (w_accept && w_last) begin
                        r_pkt_cnt <= r_pkt_cnt + 8'd1;
                        if (!w_burst_more) begin
                            r_state  <= StArb;
                            r_rr_ptr <= w_ptr_next;
                        end
                    end
                end
                default: r_state <= StArb;
            endcase

            if (w_accept) begin
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= w_last;
                r_m_tdata  <= w_tdata;
                r_m_tkeep  <= w_tkeep;
                r_m_tuser  <= w_tuser;
                r_m_tid    <= r_grant;
            end else if (bus.m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            r_is_idle <= pause && (r_state == StArb) && !w_tvalid_next;
        end
    end

    assign bus.s_tready = w_s_tready;
    assign bus.m_tvalid = r_m_tvalid;
    assign bus.m_tlast  = r_m_tlast;
    assign bus.m_tdata  = r_m_tdata;
    assign bus.m_tkeep  = r_m_tkeep;
    assign bus.m_tuser  = r_m_tuser;
    assign bus.m_tid    = r_m_tid;
    assign is_idle      = r_is_idle;
endmodule
